// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and word-addressed data memory: queues word/half/byte
// stores and drains one full-word write per cycle. Optional macro: STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          st_valid_i,
  output logic          st_ready_o,
  input  logic [1:0]    st_type_i,
  input  logic [31:0]   st_addr_i,
  input  logic [31:0]   st_data_i,
  input  logic [31:0]   st_pc_i,
  output logic          st_err_o,
  input  logic          ld_valid_i,
  input  logic [31:0]   ld_addr_i,
  output logic          ld_stall_o,
  output logic          ld_fwd_valid_o,
  output logic [31:0]   ld_fwd_data_o,
  output logic          dm_we_o,
  output logic [31:0]   dm_a_o,
  output logic [31:0]   dm_din_o,
  input  logic [31:0]   dm_dout_i,
  output logic [31:0]   dm_pc_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] TypeSw = 2'b00;
  localparam logic [1:0] TypeSh = 2'b01;
  localparam logic [1:0] TypeSb = 2'b10;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [1:0]    type_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          st_aligned;
  logic          enq, deq;

  // Alignment check; the reserved type never aligns.
  always_comb begin
    st_aligned = 1'b0;
    unique case (st_type_i)
      TypeSw:  st_aligned = (st_addr_i[1:0] == 2'b00);
      TypeSh:  st_aligned = ~st_addr_i[0];
      TypeSb:  st_aligned = 1'b1;
      default: st_aligned = 1'b0;
    endcase
  end

  assign st_ready_o = (count_q < CW'(DEPTH));
  assign st_err_o   = st_valid_i & ~st_aligned;
  assign enq        = st_valid_i & st_ready_o & st_aligned;
  assign deq        = (count_q != '0);
  assign empty_o    = ~deq;
  assign count_o    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PW'(1);
    if (deq) head_d = head_q + PW'(1);
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr_i;
      data_q[tail_q] <= st_data_i;
      type_q[tail_q] <= st_type_i;
      pc_q[tail_q]   <= st_pc_i;
    end
  end

  // Head entry merge: byte mask and lane replication, then read-modify-write.
  logic [1:0]  head_type;
  logic [1:0]  head_boff;
  logic [31:0] head_data;
  logic [3:0]  head_bmask;
  logic [31:0] head_lane;
  logic [31:0] head_wmask;

  assign head_type = type_q[head_q];
  assign head_boff = addr_q[head_q][1:0];
  assign head_data = data_q[head_q];

  always_comb begin
    head_bmask = 4'b0000;
    head_lane  = '0;
    unique case (head_type)
      TypeSw: begin
        head_bmask = 4'b1111;
        head_lane  = head_data;
      end
      TypeSh: begin
        head_bmask = head_boff[1] ? 4'b1100 : 4'b0011;
        head_lane  = {2{head_data[15:0]}};
      end
      TypeSb: begin
        head_bmask = 4'b0001 << head_boff;
        head_lane  = {4{head_data[7:0]}};
      end
      default: begin
        head_bmask = 4'b0000;
        head_lane  = '0;
      end
    endcase
  end

  assign head_wmask = {{8{head_bmask[3]}}, {8{head_bmask[2]}},
                       {8{head_bmask[1]}}, {8{head_bmask[0]}}};

  assign dm_we_o  = deq;
  assign dm_a_o   = deq ? {addr_q[head_q][31:2], 2'b00} : '0;
  assign dm_din_o = deq ? ((dm_dout_i & ~head_wmask) | (head_lane & head_wmask)) : '0;
  assign dm_pc_o  = deq ? pc_q[head_q] : '0;

  // Hazard scan walks oldest to youngest so the last hit is the youngest match.
  logic          ld_hit;
  logic [1:0]    ld_hit_type;
  logic [31:0]   ld_hit_data;
  logic [PW-1:0] scan_idx;

  always_comb begin
    ld_hit      = 1'b0;
    ld_hit_type = '0;
    ld_hit_data = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[scan_idx][31:2] == ld_addr_i[31:2])) begin
        ld_hit      = 1'b1;
        ld_hit_type = type_q[scan_idx];
        ld_hit_data = data_q[scan_idx];
      end
    end
  end

  logic unused_ld_boff;
  assign unused_ld_boff = ^ld_addr_i[1:0];

`ifdef STORE_BUFFER_FWD_EN
  logic ld_fwd;
  assign ld_fwd         = ld_valid_i & ld_hit & (ld_hit_type == TypeSw);
  assign ld_fwd_valid_o = ld_fwd;
  assign ld_fwd_data_o  = ld_fwd ? ld_hit_data : '0;
  assign ld_stall_o     = ld_valid_i & ld_hit & ~ld_fwd;
`else
  logic unused_fwd;
  assign unused_fwd     = ^{ld_hit_type, ld_hit_data};
  assign ld_fwd_valid_o = 1'b0;
  assign ld_fwd_data_o  = '0;
  assign ld_stall_o     = ld_valid_i & ld_hit;
`endif

endmodule
